// File: rtl/btn_cmd_ctrl_pkg.sv
// Shared state encodings for the button press classifier and the config sequencer.
// Both FSMs use plain binary encodings.
package btn_cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    P_UP   = 2'd0,
    P_DOWN = 2'd1,
    P_LONG = 2'd2
  } press_state_t;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_START = 2'd1,
    C_WAIT  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/btn_cmd_ctrl_press_classifier.sv
// Classifies each debounced press as short or long. Each classification is a
// one-cycle event, produced in the same cycle as the input that decides it.
module press_classifier
  import btn_cmd_ctrl_pkg::*;
#(
  parameter int LONG_PRESS = 100_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_db,
  output logic short_evt,
  output logic long_evt
);

  localparam int CW = $clog2(LONG_PRESS + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_PRESS - 1);

  press_state_t state, state_next;
  logic [CW-1:0] hold_cnt, hold_cnt_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= P_UP;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // hold_cnt counts high cycles seen so far, including the one that entered
  // P_DOWN. It stops at HOLD_LAST, so it saturates without extra logic.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    short_evt     = 1'b0;
    long_evt      = 1'b0;
    case (state)
      P_UP: begin
        if (i_btn_db) begin
          state_next    = P_DOWN;
          hold_cnt_next = CW'(1);
        end
      end
      P_DOWN: begin
        if (!i_btn_db) begin
          short_evt  = 1'b1;
          state_next = P_UP;
        end else if (hold_cnt == HOLD_LAST) begin
          long_evt   = 1'b1;
          state_next = P_LONG;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      P_LONG: begin
        if (!i_btn_db) state_next = P_UP;
      end
      default: state_next = P_UP;
    endcase
  end

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Turns classified button presses into start/done handshakes with the camera
// config engine, with one-deep request coalescing and a done timeout.
module btn_cmd_ctrl
  import btn_cmd_ctrl_pkg::*;
#(
  parameter int LONG_PRESS = 100_000_000,
  parameter int TIMEOUT    = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_db,
  input  logic i_cfg_done,
  output logic o_cfg_start,
  output logic o_mode,
  output logic o_busy,
  output logic o_cfg_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  logic short_evt, long_evt;

  press_classifier #(
    .LONG_PRESS(LONG_PRESS)
  ) u_press (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_btn_db (i_btn_db),
    .short_evt(short_evt),
    .long_evt (long_evt)
  );

  cfg_state_t    state, state_next;
  logic          pending, pending_d;
  logic          mode_next, mode_next_d;
  logic          mode_d, err_d;
  logic [TW-1:0] wait_cnt, wait_cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= C_IDLE;
      pending   <= 1'b0;
      mode_next <= 1'b0;
      o_mode    <= 1'b0;
      o_cfg_err <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_next;
      pending   <= pending_d;
      mode_next <= mode_next_d;
      o_mode    <= mode_d;
      o_cfg_err <= err_d;
      wait_cnt  <= wait_cnt_d;
    end
  end

  // o_mode is loaded on the edge into C_START so the new mode is already
  // visible alongside the start pulse. A new event always re-arms pending,
  // even in the C_START cycle that would otherwise clear it.
  always_comb begin
    state_next  = state;
    pending_d   = pending;
    mode_next_d = mode_next ^ long_evt;
    mode_d      = o_mode;
    err_d       = o_cfg_err;
    wait_cnt_d  = wait_cnt;
    case (state)
      C_IDLE: begin
        if (pending) begin
          state_next = C_START;
          mode_d     = mode_next;
        end
      end
      C_START: begin
        pending_d  = 1'b0;
        wait_cnt_d = '0;
        state_next = C_WAIT;
      end
      C_WAIT: begin
        if (i_cfg_done) begin
          state_next = C_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = C_IDLE;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      default: state_next = C_IDLE;
    endcase
    if (short_evt || long_evt) pending_d = 1'b1;
  end

  assign o_cfg_start = (state == C_START);
  assign o_busy      = (state != C_IDLE);

endmodule
